// File: rtl/key_extend_inv.sv
// Reverse AES-128 key schedule: walks from round key K10 back to K0, one key per
// valid/ready handshake, using the registered S-box ROM memory_S.

module memory_S (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  output logic [7:0] mem_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] mem_out_d, mem_out_q;

  always_comb mem_out_d = sbox(addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_out_q <= 8'h00;
    else        mem_out_q <= mem_out_d;
  end

  assign mem_out = mem_out_q;

endmodule

module key_extend_inv #(
  parameter int unsigned LAST_RD = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_in,
  input  logic         key_ready_i,
  output logic         key_valid_o,
  output logic [127:0] key_out,
  output logic [3:0]   key_rd_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LK0  = 3'd1;
  localparam logic [2:0] LK1  = 3'd2;
  localparam logic [2:0] LK2  = 3'd3;
  localparam logic [2:0] LK3  = 3'd4;
  localparam logic [2:0] LKW  = 3'd5;
  localparam logic [2:0] UPD  = 3'd6;
  localparam logic [2:0] OUT  = 3'd7;

  localparam logic [3:0] LAST_RD_W = 4'(LAST_RD);

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [2:0]   state_d, state_q;
  logic [127:0] cur_d, cur_q;
  logic [3:0]   r_d, r_q;
  logic [31:0]  sb_d, sb_q;
  logic         key_valid_d, key_valid_q;
  logic [127:0] key_out_d, key_out_q;
  logic [3:0]   key_rd_d, key_rd_q;
  logic         busy_d, busy_q;
  logic         done_d, done_q;

  logic [7:0]   sbox_addr;
  logic [7:0]   sbox_data;
  logic [31:0]  w3;
  logic [31:0]  g_w3;
  logic [127:0] prev_key;

  memory_S u_sbox (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (sbox_addr),
    .mem_out(sbox_data)
  );

  // With Kr = {w4,w5,w6,w7}: w3 = w7^w6, w2 = w6^w5, w1 = w5^w4, w0 = w4^g(w3).
  always_comb begin
    w3       = cur_q[31:0] ^ cur_q[63:32];
    g_w3     = {sb_q[23:16] ^ rcon(r_q - 4'd1), sb_q[15:8], sb_q[7:0], sb_q[31:24]};
    prev_key = {cur_q[127:96] ^ g_w3,
                cur_q[127:96] ^ cur_q[95:64],
                cur_q[95:64] ^ cur_q[63:32],
                w3};
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    r_d         = r_q;
    sb_d        = sb_q;
    key_valid_d = key_valid_q;
    key_out_d   = key_out_q;
    key_rd_d    = key_rd_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sbox_addr   = 8'h00;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cur_d   = key_in;
          r_d     = LAST_RD_W;
          busy_d  = 1'b1;
          state_d = LK0;
        end
      end
      LK0: begin
        sbox_addr = w3[7:0];
        state_d   = LK1;
      end
      LK1: begin
        sbox_addr  = w3[15:8];
        sb_d[7:0]  = sbox_data;
        state_d    = LK2;
      end
      LK2: begin
        sbox_addr   = w3[23:16];
        sb_d[15:8]  = sbox_data;
        state_d     = LK3;
      end
      LK3: begin
        sbox_addr    = w3[31:24];
        sb_d[23:16]  = sbox_data;
        state_d      = LKW;
      end
      LKW: begin
        sb_d[31:24] = sbox_data;
        state_d     = UPD;
      end
      UPD: begin
        cur_d       = prev_key;
        key_out_d   = prev_key;
        key_rd_d    = r_q - 4'd1;
        r_d         = r_q - 4'd1;
        key_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (key_valid_q && key_ready_i) begin
          key_valid_d = 1'b0;
          if (key_rd_q == 4'd0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LK0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      r_q         <= '0;
      sb_q        <= '0;
      key_valid_q <= 1'b0;
      key_out_q   <= '0;
      key_rd_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      r_q         <= r_d;
      sb_q        <= sb_d;
      key_valid_q <= key_valid_d;
      key_out_q   <= key_out_d;
      key_rd_q    <= key_rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_out     = key_out_q;
  assign key_rd_o    = key_rd_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_key_extend_inv.sv
// Bench for key_extend_inv: a forward AES-128 expansion model (log/antilog S-box)
// supplies the expected reverse key sequence; a negedge monitor checks every cycle.

module tb_key_extend_inv;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] key_in;
  logic         key_ready_i;
  logic         key_valid_o;
  logic [127:0] key_out;
  logic [3:0]   key_rd_o;
  logic         busy_o;
  logic         done_o;

  key_extend_inv #(.LAST_RD(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .key_in     (key_in),
    .key_ready_i(key_ready_i),
    .key_valid_o(key_valid_o),
    .key_out    (key_out),
    .key_rd_o   (key_rd_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model: GF(2^8) via exp/log tables ----------------
  logic [7:0] exp_t [0:255];
  int         log_t [0:255];

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv;
    inv = (x == 8'h00) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  initial begin
    exp_t[0] = 8'h01;
    for (int i = 1; i < 256; i++) exp_t[i] = exp_t[i-1] ^ xt(exp_t[i-1]);
    for (int i = 0; i < 256; i++) log_t[i] = 0;
    for (int i = 0; i < 255; i++) log_t[exp_t[i]] = i;
  end

  logic [127:0] pend [0:10];

  // Standard forward expansion from K0; pend[r] = round key r.
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [127:0] m_tab [0:10];
  logic         m_busy  = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_done  = 1'b0;
  int           m_cnt   = 0;
  int           m_rd    = 9;
  logic [127:0] obs [0:9];

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      chk("rst_valid", 128'(key_valid_o), 128'(0));
      chk("rst_key",   key_out,           128'(0));
      chk("rst_rd",    128'(key_rd_o),    128'(0));
      chk("rst_busy",  128'(busy_o),      128'(0));
      chk("rst_done",  128'(done_o),      128'(0));
      m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else begin
      chk("busy",  128'(busy_o),      128'(m_busy));
      chk("done",  128'(done_o),      128'(m_done));
      chk("valid", 128'(key_valid_o), 128'(m_valid));
      if (m_valid) begin
        chk("key", key_out,        m_tab[m_rd]);
        chk("rd",  128'(key_rd_o), 128'(m_rd));
        if (key_rd_o < 4'd10) obs[key_rd_o] = key_out;
      end
      m_done = 1'b0;
      if (!m_busy && start_i) begin
        for (int r = 0; r < 11; r++) m_tab[r] = pend[r];
        chk("start_key", key_in, pend[10]);
        m_busy = 1'b1; m_cnt = 6; m_rd = 9;
      end else if (m_valid && key_ready_i) begin
        m_valid = 1'b0;
        if (m_rd == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_rd--; m_cnt = 6;
        end
      end else if (m_busy && !m_valid) begin
        m_cnt--;
        if (m_cnt == 0) m_valid = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_start(input logic [127:0] k0);
    expand(k0);
    key_in  = pend[10];
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (done_o) return;
    end
    chk("done_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_valid_rd(input logic [3:0] rd, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (key_valid_o && key_rd_o == rd) return;
    end
    chk("valid_timeout", 128'(0), 128'(1));
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 10; i++) obs[i] = '0;
  endtask

  logic [127:0] k0r, held;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; key_in = '0; key_ready_i = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // model pinned against FIPS-197 appendix values and S-box entries
    chk("model_sbox00", 128'(sb(8'h00)), 128'(8'h63));
    chk("model_sbox53", 128'(sb(8'h53)), 128'(8'hed));
    expand(FIPS_K0);
    chk("model_k10", pend[10], FIPS_K10);
    chk("model_k9",  pend[9],  FIPS_K9);
    chk("model_k1",  pend[1],  FIPS_K1);

    // FIPS key, ready tied high
    key_ready_i = 1'b1;
    do_start(FIPS_K0);
    wait_done(200);
    chk("fips_k9", obs[9], FIPS_K9);
    chk("fips_k1", obs[1], FIPS_K1);
    chk("fips_k0", obs[0], FIPS_K0);

    // back-to-back start while done_o is high
    clear_obs();
    do_start(FIPS_K0);
    wait_done(200);
    chk("b2b_k9", obs[9], FIPS_K9);

    // backpressure at rd=5
    k0r = rnd128();
    do_start(k0r);
    wait_valid_rd(4'd5, 100);
    key_ready_i = 1'b0;
    held = key_out;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_key",   key_out,           held);
    chk("bp_rd",    128'(key_rd_o),    128'(5));
    chk("bp_valid", 128'(key_valid_o), 128'(1));
    key_ready_i = 1'b1;
    wait_done(200);
    chk("bp_k0", obs[0], k0r);

    // random ready with spurious starts while busy
    for (int k = 0; k < 20; k++) begin
      k0r = rnd128();
      clear_obs();
      do_start(k0r);
      for (int c = 0; c < 2000; c++) begin
        @(posedge clk); #1;
        if (done_o) break;
        key_ready_i = 1'($urandom_range(0, 1));
        start_i     = ($urandom_range(0, 7) == 0);
        key_in      = rnd128();
        if (c == 1999) chk("rand_timeout", 128'(0), 128'(1));
      end
      start_i = 1'b0;
      chk("rand_k0", obs[0], k0r);
    end

    // reset during LK2 of the rd=6 step
    key_ready_i = 1'b1;
    do_start(rnd128());
    wait_valid_rd(4'd7, 100);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(key_valid_o), 128'(0));
    chk("arst_busy",  128'(busy_o),      128'(0));
    chk("arst_key",   key_out,           128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_idle", 128'(key_valid_o), 128'(0));

    // clean run after reset, with an ignored start carrying another key
    clear_obs();
    do_start(FIPS_K0);
    repeat (10) @(posedge clk);
    #1 start_i = 1'b1; key_in = rnd128();
    @(posedge clk);
    #1 start_i = 1'b0;
    chk("busy_hold", 128'(busy_o), 128'(1));
    wait_done(200);
    chk("rst_k9", obs[9], FIPS_K9);
    chk("rst_k0", obs[0], FIPS_K0);

    @(posedge clk);
    #1 chk("done_once", 128'(done_o), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
